// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: launches mult/div on an external multiplier and divider,
// stalls the pipeline until the result is ready, then writes HI/LO exactly once.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_adv,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        stallreq,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StMulWait, StDivRun, StDone} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sgn_q;
  logic [63:0] result_q;
  logic        wr_pend_q;
  logic        block_q;

  // op bit order: [0] mult, [1] multu, [2] div, [3] divu
  logic op_is_mul;
  logic op_sgn;
  logic accept;

  assign op_is_mul = op[0] | op[1];
  assign op_sgn    = op[0] | op[2];
  assign accept    = (state_q == StIdle) && op_valid && (op != 4'b0) && !flush && !block_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      result_q  <= '0;
      wr_pend_q <= 1'b0;
      block_q   <= 1'b0;
    end else if (flush) begin
      state_q   <= StIdle;
      wr_pend_q <= 1'b0;
      // A flushed DONE without ex_adv may leave the finished instruction sitting in EX.
      block_q   <= (state_q == StDone) && !ex_adv;
    end else begin
      unique case (state_q)
        StIdle: begin
          block_q <= 1'b0;
          if (accept) begin
            a_q   <= src1;
            b_q   <= src2;
            sgn_q <= op_sgn;
            if (op_is_mul) begin
              cnt_q   <= 4'(MUL_LAT - 1);
              state_q <= StMulWait;
            end else if (src2 != 32'b0) begin
              state_q <= StDivRun;
            end else begin
              result_q  <= {src1, 32'hFFFF_FFFF};
              wr_pend_q <= 1'b1;
              state_q   <= StDone;
            end
          end
        end
        StMulWait: begin
          if (cnt_q == 4'd0) begin
            result_q  <= mul_result;
            wr_pend_q <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDivRun: begin
          if (div_ready) begin
            result_q  <= div_result;
            wr_pend_q <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          wr_pend_q <= 1'b0;
          if (ex_adv) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    stallreq   = 1'b0;
    busy       = 1'b0;
    mul_signed = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    div_signed = 1'b0;
    div_a      = '0;
    div_b      = '0;
    div_start  = 1'b0;
    div_annul  = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_wdata   = '0;
    lo_wdata   = '0;
    if (!rst) begin
      busy     = state_q != StIdle;
      stallreq = accept || (state_q == StMulWait) || (state_q == StDivRun);
      // Operands pass straight through on accept so the multiplier latency starts there.
      if (state_q == StIdle) begin
        if (accept) begin
          mul_signed = op_sgn;
          mul_a      = src1;
          mul_b      = src2;
          div_signed = op_sgn;
          div_a      = src1;
          div_b      = src2;
        end
      end else begin
        mul_signed = sgn_q;
        mul_a      = a_q;
        mul_b      = b_q;
        div_signed = sgn_q;
        div_a      = a_q;
        div_b      = b_q;
      end
      div_start = state_q == StDivRun;
      div_annul = (state_q == StDivRun) && flush;
      if ((state_q == StDone) && wr_pend_q && !flush) begin
        hi_we    = 1'b1;
        lo_we    = 1'b1;
        hi_wdata = result_q[63:32];
        lo_wdata = result_q[31:0];
      end
    end
  end

endmodule
